// File: rtl/avalon_gpio_port.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_gpio_port
//  Purpose  : Avalon-MM slave GPIO port. WIDTH registered outputs with atomic
//             set/clear, WIDTH synchronised inputs with per-bit edge capture
//             (write-1-to-clear) and a maskable level interrupt.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             address/chipselect/write_n/writedata/readdata - Avalon-MM slave
//             in_port             - asynchronous external inputs
//             out_port            - registered outputs
//             irq                 - level interrupt, active high
//  Register map:
//             0 DATA (R: synced inputs, W: out_port)   1 OUTVAL (R)
//             2 IRQ_MASK (R/W)   3 EDGE_CAPTURE (R, W1C)
//             4 OUTSET (W)       5 OUTCLEAR (W)        6,7 reserved
//  Revision : 1.0 - initial release
// ============================================================================
module avalon_gpio_port #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] c_ADDR_DATA     = 3'd0;
    localparam logic [2:0] c_ADDR_OUTVAL   = 3'd1;
    localparam logic [2:0] c_ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLR   = 3'd5;
    localparam logic [1:0] c_PRIMED        = 2'd3;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_irq_mask;
    logic [1:0]       r_prime;
    logic             r_irq;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] w_mask_next;
    logic [WIDTH-1:0] w_cap_next;
    logic             w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately ignored.
    assign w_unused_wd = ^writedata;

    // Edge polarity is fixed at elaboration time.
    generate
        if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = ~r_s2 & r_s3;
        end else if (EDGE_TYPE == 2) begin : g_edge_any
            assign w_edge = r_s2 ^ r_s3;
        end else begin : g_edge_rise
            assign w_edge = r_s2 & ~r_s3;
        end
    endgenerate

    // Detection stays off until the synchroniser has been refilled after
    // reset, so an input held high through reset is not seen as an edge.
    assign w_det = (r_prime == c_PRIMED) ? w_edge : '0;

    always_comb begin
        w_out_next  = r_out;
        w_mask_next = r_irq_mask;
        w_clr       = '0;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:     w_out_next  = w_wd;
                c_ADDR_IRQ_MASK: w_mask_next = w_wd;
                c_ADDR_EDGE_CAP: w_clr       = w_wd;
                c_ADDR_OUTSET:   w_out_next  = r_out | w_wd;
                c_ADDR_OUTCLR:   w_out_next  = r_out & ~w_wd;
                default:         ;
            endcase
        end
        // A new edge beats a simultaneous clear of the same bit.
        w_cap_next = (r_edge_cap & ~w_clr) | w_det;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= RESET_VALUE[WIDTH-1:0];
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_edge_cap <= '0;
            r_irq_mask <= '0;
            r_prime    <= 2'd0;
            r_irq      <= 1'b0;
        end else begin
            r_out      <= w_out_next;
            r_s1       <= in_port;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_edge_cap <= w_cap_next;
            r_irq_mask <= w_mask_next;
            if (r_prime != c_PRIMED) begin
                r_prime <= r_prime + 2'd1;
            end
            // Registered from next-state values so irq lines up with the
            // capture register rather than lagging it by a cycle.
            r_irq      <= |(w_cap_next & w_mask_next);
        end
    end

    // Zero-latency read mux; independent of chipselect.
    always_comb begin
        readdata = '0;
        case (address)
            c_ADDR_DATA:     readdata[WIDTH-1:0] = r_s2;
            c_ADDR_OUTVAL:   readdata[WIDTH-1:0] = r_out;
            c_ADDR_IRQ_MASK: readdata[WIDTH-1:0] = r_irq_mask;
            c_ADDR_EDGE_CAP: readdata[WIDTH-1:0] = r_edge_cap;
            default:         readdata = '0;
        endcase
    end

    assign out_port = r_out;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_avalon_gpio_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avalon_gpio_port
//  Purpose  : Self-checking bench for avalon_gpio_port (WIDTH=8,
//             RESET_VALUE=8'hA5, rising-edge capture). Directed scenarios
//             followed by randomized traffic, all checked against a
//             cycle-level behavioural model of the register file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_gpio_port;

    localparam int          WIDTH = 8;
    localparam logic [31:0] RV    = 32'h0000_00A5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       address = 3'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port = '0;
    logic [WIDTH-1:0] out_port;
    logic             irq;

    int n_checks = 0;
    int n_pass   = 0;

    avalon_gpio_port #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .EDGE_TYPE   (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // in_hist[0] is the input sampled at the latest edge, [1] the one before.
    logic [7:0] m_out, m_mask, m_cap;
    logic       m_irq;
    logic [7:0] in_hist [3];
    int         edges_since_reset;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, in_hist[1]};
            3'd1:    return {24'h0, m_out};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic cycle(input logic rst_i, input logic cs_i, input logic wn_i,
                         input logic [2:0] a, input logic [31:0] wd, input logic [7:0] inp);
        logic [7:0] n_out, n_mask, n_cap, det, clr;
        logic       wr;
        reset = rst_i; chipselect = cs_i; write_n = wn_i;
        address = a; writedata = wd; in_port = inp;
        wr = cs_i & ~wn_i;
        // Edge seen by software: input went 0->1 between the two oldest
        // visible samples, and at least three edges have passed since reset.
        det   = (edges_since_reset >= 3) ? (in_hist[1] & ~in_hist[2]) : 8'h0;
        clr   = (wr && a == 3'd3) ? wd[7:0] : 8'h0;
        n_cap = (m_cap & ~clr) | det;
        n_mask = (wr && a == 3'd2) ? wd[7:0] : m_mask;
        n_out = m_out;
        if (wr && a == 3'd0) n_out = wd[7:0];
        if (wr && a == 3'd4) n_out = m_out | wd[7:0];
        if (wr && a == 3'd5) n_out = m_out & ~wd[7:0];
        @(posedge clk);
        #1;
        if (rst_i) begin
            m_out = RV[7:0]; m_mask = '0; m_cap = '0; m_irq = 1'b0;
            for (int i = 0; i < 3; i++) in_hist[i] = '0;
            edges_since_reset = 0;
        end else begin
            m_out = n_out; m_mask = n_mask; m_cap = n_cap;
            m_irq = |(n_cap & n_mask);
            in_hist[2] = in_hist[1]; in_hist[1] = in_hist[0]; in_hist[0] = inp;
            if (edges_since_reset < 3) edges_since_reset++;
        end
        check("out_port", {24'h0, out_port}, {24'h0, m_out});
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        check($sformatf("readdata@%0d", a), readdata, model_read(a));
    endtask

    task automatic idle(input logic [2:0] a, input logic [7:0] inp);
        cycle(1'b0, 1'b0, 1'b1, a, 32'h0, inp);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [7:0] inp);
        cycle(1'b0, 1'b1, 1'b0, a, wd, inp);
    endtask

    logic [7:0] r_inp;

    initial begin
        // Reset and register map after reset
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
        check("rst_out", {24'h0, out_port}, 32'hA5);
        check("rst_irq", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            idle(3'(a), 8'h00);
            check($sformatf("rst_read@%0d", a), readdata, (a == 1) ? 32'hA5 : 32'h0);
        end

        // Output write / set / clear back-to-back
        wr_reg(3'd0, 32'hFFFF_FF0F, 8'h00);
        check("data_wr", {24'h0, out_port}, 32'h0F);
        wr_reg(3'd4, 32'h0000_0030, 8'h00);
        check("outset", {24'h0, out_port}, 32'h3F);
        wr_reg(3'd5, 32'h0000_0001, 8'h00);
        check("outclr", {24'h0, out_port}, 32'h3E);
        idle(3'd1, 8'h00);
        check("outval", readdata, 32'h3E);

        // Edge capture latency and irq clear
        wr_reg(3'd2, 32'h0000_0004, 8'h00);
        idle(3'd3, 8'h04);                       // edge k samples the rise
        idle(3'd3, 8'h04);                       // k+1
        check("cap_k1", readdata, 32'h0);
        check("irq_k1", {31'h0, irq}, 32'h0);
        idle(3'd3, 8'h04);                       // k+2
        check("cap_k2", readdata, 32'h04);
        check("irq_k2", {31'h0, irq}, 32'h1);
        wr_reg(3'd3, 32'h0000_0004, 8'h04);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Input held high through reset must not be captured
        cycle(1'b1, 1'b0, 1'b1, 3'd3, 32'h0, 8'hFF);
        wr_reg(3'd2, 32'h0000_00FF, 8'hFF);
        for (int i = 0; i < 19; i++) begin
            idle(3'd3, 8'hFF);
            check("prime_cap", readdata, 32'h0);
        end
        idle(3'd0, 8'hFF);
        check("prime_data", readdata, 32'hFF);

        // Set wins over simultaneous clear; then reset drops irq
        idle(3'd3, 8'h00);
        idle(3'd3, 8'h00);
        idle(3'd3, 8'h00);
        wr_reg(3'd3, 32'h0000_00FF, 8'h02);      // clear anything from the fall
        idle(3'd3, 8'h02);                       // k+1: edge now visible
        wr_reg(3'd3, 32'h0000_0002, 8'h02);      // k+2: clear coincides with set
        check("set_wins", readdata & 32'h2, 32'h2);
        check("set_wins_irq", {31'h0, irq}, 32'h1);

        // Reserved reads, unselected write, reset while irq is high
        idle(3'd6, 8'h02);
        check("rsvd6", readdata, 32'h0);
        idle(3'd7, 8'h02);
        check("rsvd7", readdata, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_0055, 8'h02);
        check("cs0_write", {24'h0, out_port}, 32'hA5);
        cycle(1'b1, 1'b0, 1'b1, 3'd3, 32'h0, 8'h02);
        check("rst_irq_drop", {31'h0, irq}, 32'h0);

        // Randomized traffic
        r_inp = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r_inp = r_inp ^ (8'($urandom) & 8'($urandom));
            cycle(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom),
                  3'($urandom), $urandom, r_inp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
